// File: rtl/tpum_xbox_seq_if.sv
// XBOX row memory port between the TriplePuM sequencer (master) and XBOX memory (slave).
// Strobe semantics: mem_rd/mem_wr are single-cycle commands with no back-pressure; a read
// returns mem_rdata a fixed latency later, and addr/wdata are zero whenever their strobe is low.
interface tpum_xbox_seq_if #(
    parameter int DATA_W = 1024,
    parameter int ADDR_W = 14
);
    logic              mem_rd;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_rd,
        output mem_wr,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_rd,
        input  mem_wr,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/tpum_xbox_seq.sv
// XBOX-side row sequencer: per row reads A and B into R1/R2, triggers the PuM compute,
// waits for calc_done (with timeout) and writes the RA result row back at base C.
module tpum_xbox_seq #(
    parameter int DATA_W       = 1024,
    parameter int ADDR_W       = 14,
    parameter int RD_LAT       = 2,
    parameter int CALC_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [15:0]       dim_rows,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [ADDR_W-1:0] base_c,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       row_idx,
    tpum_xbox_seq_if.master   mem,
    output logic [DATA_W-1:0] op_data,
    output logic              r1_load,
    output logic              r2_load,
    output logic              calc_start,
    input  logic              calc_done,
    input  logic [DATA_W-1:0] ra_data,
    output logic [3:0]        state_dbg
);
    localparam int LAT_W = 4;
    localparam int TO_W  = $clog2(CALC_TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_RD_A, S_WAIT_A, S_RD_B, S_WAIT_B,
        S_CALC, S_WAIT_CALC, S_WR_C, S_FIN
    } state_t;

    state_t            state, state_nxt;
    logic [15:0]       dim_q;
    logic [ADDR_W-1:0] base_a_q, base_b_q, base_c_q;
    logic [LAT_W-1:0]  lat_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [ADDR_W-1:0] row_off;
    logic              last_row;
    logic              lat_hit;
    logic              accept;
    logic              timeout;

    assign row_off  = ADDR_W'(row_idx);
    assign last_row = (row_idx + 16'd1) == dim_q;
    assign lat_hit  = lat_cnt == LAT_W'(RD_LAT);
    assign accept   = (state == S_IDLE) && start;
    assign timeout  = (state == S_WAIT_CALC) && !calc_done &&
                      (to_cnt == TO_W'(CALC_TIMEOUT - 1));
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // WAIT_B lingers one extra cycle so r2_load gets its own cycle before CALC.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (start) state_nxt = (dim_rows == 16'd0) ? S_FIN : S_RD_A;
            S_RD_A:      state_nxt = S_WAIT_A;
            S_WAIT_A:    if (lat_hit) state_nxt = S_RD_B;
            S_RD_B:      state_nxt = S_WAIT_B;
            S_WAIT_B:    if (r2_load) state_nxt = S_CALC;
            S_CALC:      state_nxt = S_WAIT_CALC;
            S_WAIT_CALC: begin
                if (calc_done)    state_nxt = S_WR_C;
                else if (timeout) state_nxt = S_FIN;
            end
            S_WR_C:      state_nxt = last_row ? S_FIN : S_RD_A;
            S_FIN:       state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy           = (state != S_IDLE) && (state != S_FIN);
        done           = (state == S_FIN);
        calc_start     = (state == S_CALC);
        mem.mem_rd     = 1'b0;
        mem.mem_wr     = 1'b0;
        mem.mem_addr   = '0;
        mem.mem_wdata  = '0;
        case (state)
            S_RD_A: begin
                mem.mem_rd   = 1'b1;
                mem.mem_addr = base_a_q + row_off;
            end
            S_RD_B: begin
                mem.mem_rd   = 1'b1;
                mem.mem_addr = base_b_q + row_off;
            end
            S_WR_C: begin
                mem.mem_wr    = 1'b1;
                mem.mem_addr  = base_c_q + row_off;
                mem.mem_wdata = ra_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dim_q    <= '0;
            base_a_q <= '0;
            base_b_q <= '0;
            base_c_q <= '0;
            row_idx  <= '0;
            err      <= 1'b0;
            lat_cnt  <= '0;
            to_cnt   <= '0;
            op_data  <= '0;
            r1_load  <= 1'b0;
            r2_load  <= 1'b0;
        end else begin
            r1_load <= 1'b0;
            r2_load <= 1'b0;
            if (accept) begin
                dim_q    <= dim_rows;
                base_a_q <= base_a;
                base_b_q <= base_b;
                base_c_q <= base_c;
                row_idx  <= '0;
                err      <= 1'b0;
            end
            // lat_cnt counts the cycles since the read strobe; data is valid when it equals RD_LAT.
            if (state == S_RD_A || state == S_RD_B) lat_cnt <= LAT_W'(1);
            else if (state == S_WAIT_A || state == S_WAIT_B) lat_cnt <= lat_cnt + LAT_W'(1);
            if ((state == S_WAIT_A || state == S_WAIT_B) && lat_hit) begin
                op_data <= mem.mem_rdata;
                r1_load <= (state == S_WAIT_A);
                r2_load <= (state == S_WAIT_B);
            end
            if (state == S_CALC)           to_cnt <= '0;
            else if (state == S_WAIT_CALC) to_cnt <= to_cnt + TO_W'(1);
            if (timeout) err <= 1'b1;
            if (state == S_WR_C && !last_row) row_idx <= row_idx + 16'd1;
        end
    end
endmodule

// File: doc/tpum_xbox_seq.md
Name: tpum_xbox_seq

Overview:
XBOX-side sequencer for the TriplePuM. A software start triggers a row loop over XBOX memory:
- read row of operand A, load it into R1;
- read row of operand B, load it into R2;
- pulse the PuM compute engine and wait for its done;
- write the RA result row back to XBOX at base C.

It sits between the APB register file (dim/base/start registers) and the 1024-bit XBOX memory port.

Parameters:
- DATA_W, 1024, XBOX row width in bits.
- ADDR_W, 14, XBOX row address width.
- RD_LAT, 2, fixed XBOX read latency in cycles, from the mem_rd cycle to the cycle mem_rdata is valid; legal range 1..7.
- CALC_TIMEOUT, 1024, maximum number of cycles to wait for calc_done before aborting.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle start pulse from the register file
- dim_rows  in  16  number of rows to process
- base_a  in  ADDR_W  XBOX row address of operand A row 0
- base_b  in  ADDR_W  XBOX row address of operand B row 0
- base_c  in  ADDR_W  XBOX row address of result row 0
- busy  out  1  high while a job is in progress
- done  out  1  one-cycle pulse at job end
- err  out  1  sticky error flag; cleared by the next accepted start
- row_idx  out  16  current row index
- mem_rd  out  1  XBOX read strobe, one cycle
- mem_wr  out  1  XBOX write strobe, one cycle
- mem_addr  out  ADDR_W  XBOX row address
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data, valid RD_LAT cycles after mem_rd
- op_data  out  DATA_W  registered operand row to R1/R2
- r1_load  out  1  op_data is valid for R1 (one-cycle pulse)
- r2_load  out  1  op_data is valid for R2 (one-cycle pulse)
- calc_start  out  1  one-cycle compute trigger
- calc_done  in  1  compute complete (level or pulse)
- ra_data  in  DATA_W  result row from RA

Behaviour:
Reset (asynchronous, applies at any time):
- All outputs go to 0, the FSM goes to IDLE, and all counters clear.
- Reset mid-job aborts the job with no done pulse and no further memory strobes.

States: IDLE, RD_A, WAIT_A, RD_B, WAIT_B, CALC, WAIT_CALC, WR_C, FIN.

IDLE:
- start=1: latch dim_rows/base_a/base_b/base_c, clear err, row_idx=0, busy=1 from the next cycle.
- If latched dim_rows==0, go to FIN with no memory access; otherwise go to RD_A.
- start while busy=1 is ignored, and the latched values are unaffected.

RD_A: mem_rd=1 and mem_addr=(base_a+row_idx) for one cycle, then go to WAIT_A with a latency counter.

WAIT_A:
- At the edge ending cycle RD_A+RD_LAT, mem_rdata is captured into op_data.
- The next cycle has r1_load=1, and RD_B is entered in that same cycle (mem_rd for B coincides with r1_load).

RD_B / WAIT_B: same as A with base_b; r2_load=1 for one cycle, then go to CALC.

CALC: calc_start=1 for one cycle, then go to WAIT_CALC with the timeout counter cleared.

WAIT_CALC:
- calc_done sampled high → WR_C.
- calc_done is ignored in every other state.
- If the counter reaches CALC_TIMEOUT without done: err=1, go to FIN, no write.

WR_C: mem_wr=1, mem_addr=(base_c+row_idx), mem_wdata=ra_data for one cycle, then row_idx increments.
- If row_idx+1==dim_rows, go to FIN; else go to RD_A.

FIN: done=1 for one cycle, busy drops to 0 in the same cycle, then go to IDLE. row_idx holds its last value.

Address arithmetic:
- Addresses are modulo 2^ADDR_W with silent wrap, e.g. base 0x3FFF + 1 → 0x0000.
- row_idx is truncated to ADDR_W for the add.

Strobe rules:
- mem_rd and mem_wr are never high in the same cycle.
- mem_addr and mem_wdata are 0 whenever their strobe is low.

Row timing (RD_LAT=2, calc_done high in cycle k relative to RD_A at cycle 0):
- rd A at cycle 0
- r1_load + rd B at cycle 3
- r2_load at cycle 6
- calc_start at cycle 7
- wr C at cycle k+1
- next rd A, or done, at cycle k+2

Test Plan:
- dim_rows=1, base_a=0x10, base_b=0x20, base_c=0x30, calc_done 3 cycles after calc_start:
  → rd 0x10, rd 0x20, wr 0x30 with wdata=ra_data; done 1 cycle; err=0; busy exactly the job length.
- dim_rows=3 with memory model row=addr pattern:
  → op_data on r1_load = pattern(0x10+i), on r2_load = pattern(0x20+i); writes to 0x30, 0x31, 0x32 in order; row_idx ends at 2.
- base_c=0x3FFF, dim_rows=2:
  → writes to 0x3FFF then 0x0000 (wrap); no err.
- dim_rows=0:
  → done pulses within 2 cycles of start; no mem_rd/mem_wr/calc_start.
- calc_done never asserted, CALC_TIMEOUT=16:
  → err=1 and done after 16 cycles in WAIT_CALC; no mem_wr; a second start clears err.
- start pulse during busy, and rst_n low during WAIT_B:
  → the extra start is ignored; on reset all outputs are 0 immediately with no done pulse; a fresh start afterwards runs normally.
